// File: rtl/ps2_key_decoder_if.sv
// Event handshake bundle between ps2_key_decoder (master) and its consumer (slave).
// The master presents the FIFO head on ev_*; the consumer pops it with ev_ready.
interface ps2_key_decoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_break,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_break,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: synchronise and glitch-filter the pad lines, frame
// 11-bit packets with parity/stop/watchdog checks, fold E0/F0 prefixes into make/break
// events, queue them in a fall-through FIFO and track held levels for Enter and arrows.
// Optional build macro PS2_TYPEMATIC_SUPPRESS_EN drops repeated makes of the key that
// was last pressed and not yet released.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a PS/2 clock fall with data low (start bit)
// S_RX    | shifting in 8 data, parity and stop bits; watchdog running
// S_CHECK | one cycle to validate stop and odd parity, then back to IDLE
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_dat,
    ps2_key_decoder_if.master     ev,
    output logic [4:0]            key_held,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_CHECK} state_t;

    // input conditioning
    logic [1:0]            clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [FILTER_LEN-1:0] clk_sr_q, clk_sr_d, dat_sr_q, dat_sr_d;
    logic                  clk_f_q, clk_f_d, dat_f_q, dat_f_d;
    logic                  fall;

    // framer
    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            sh_q, sh_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  frame_err_q, frame_err_d;
    logic                  byte_vld_q, byte_vld_d;
    logic [7:0]            byte_q, byte_d;

    // decoder
    logic                  ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [4:0]            key_held_q, key_held_d;
    logic                  push;
    logic [9:0]            ev_word;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    logic                  last_vld_q, last_vld_d;
    logic [8:0]            last_key_q, last_key_d;
`endif

    // event FIFO; word = {ext, break, code}
    logic [9:0]            mem_q [FIFO_DEPTH];
    logic [9:0]            mem_d [FIFO_DEPTH];
    logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
    logic                  ovf_q, ovf_d;
    logic                  empty, full, pop, wr_en;

    // synchroniser and all-ones/all-zeros glitch filter for both pad lines
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        clk_sr_d   = {clk_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
        dat_sr_d   = {dat_sr_q[FILTER_LEN-2:0], dat_sync_q[1]};
        clk_f_d    = clk_f_q;
        dat_f_d    = dat_f_q;
        if (&clk_sr_q)       clk_f_d = 1'b1;
        else if (~|clk_sr_q) clk_f_d = 1'b0;
        if (&dat_sr_q)       dat_f_d = 1'b1;
        else if (~|dat_sr_q) dat_f_d = 1'b0;
        fall = clk_f_q & ~clk_f_d;
    end

    // frame FSM next state, bit shifter and down-counting watchdog
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        wd_d        = wd_q;
        frame_err_d = 1'b0;
        byte_vld_d  = 1'b0;
        byte_d      = byte_q;
        case (state_q)
            S_IDLE: begin
                wd_d = WD_LOAD;
                if (fall && !dat_f_q) begin
                    state_d   = S_RX;
                    bit_cnt_d = 4'd0;
                end
            end
            S_RX: begin
                if (fall) begin
                    sh_d      = {dat_f_q, sh_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    wd_d      = WD_LOAD;
                    if (bit_cnt_q == 4'd9) state_d = S_CHECK;
                end else if (wd_q == '0) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            S_CHECK: begin
                // sh_q = {stop, parity, data[7:0]}; odd parity over data+parity
                if (sh_q[9] && (^sh_q[8:0])) begin
                    byte_vld_d = 1'b1;
                    byte_d     = sh_q[7:0];
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // prefix folding, held-key levels and optional typematic suppression
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        key_held_d = key_held_q;
        push       = 1'b0;
        ev_word    = {ext_pend_q, brk_pend_q, byte_q};
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
        last_vld_d = last_vld_q;
        last_key_d = last_key_q;
`endif
        if (byte_vld_q) begin
            case (byte_q)
                8'hE0: ext_pend_d = 1'b1;
                8'hF0: brk_pend_d = 1'b1;
                8'hE1: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                default: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    push       = 1'b1;
                    if (!ext_pend_q && byte_q == 8'h5A) key_held_d[0] = !brk_pend_q;
                    if (ext_pend_q) begin
                        case (byte_q)
                            8'h75:   key_held_d[1] = !brk_pend_q;
                            8'h72:   key_held_d[2] = !brk_pend_q;
                            8'h6B:   key_held_d[3] = !brk_pend_q;
                            8'h74:   key_held_d[4] = !brk_pend_q;
                            default: ;
                        endcase
                    end
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
                    if (!brk_pend_q) begin
                        if (last_vld_q && last_key_q == {ext_pend_q, byte_q}) begin
                            push = 1'b0;
                        end else begin
                            last_vld_d = 1'b1;
                            last_key_d = {ext_pend_q, byte_q};
                        end
                    end else if (last_vld_q && last_key_q == {ext_pend_q, byte_q}) begin
                        last_vld_d = 1'b0;
                    end
`endif
                end
            endcase
        end
    end

    // fall-through FIFO; a push into a full FIFO only lands if the head pops this cycle
    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop   = !empty && ev.ev_ready;
        wr_en = push && (!full || pop);
        ovf_d = push && full && !pop;
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (wr_en) begin
            mem_d[wr_q[AW-1:0]] = ev_word;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
    end

    // all state registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            clk_sr_q    <= '1;
            dat_sr_q    <= '1;
            clk_f_q     <= 1'b1;
            dat_f_q     <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            wd_q        <= '0;
            frame_err_q <= 1'b0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_held_q  <= '0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
            last_vld_q  <= 1'b0;
            last_key_q  <= '0;
`endif
            mem_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_sr_q    <= clk_sr_d;
            dat_sr_q    <= dat_sr_d;
            clk_f_q     <= clk_f_d;
            dat_f_q     <= dat_f_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            wd_q        <= wd_d;
            frame_err_q <= frame_err_d;
            byte_vld_q  <= byte_vld_d;
            byte_q      <= byte_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            key_held_q  <= key_held_d;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
            last_vld_q  <= last_vld_d;
            last_key_q  <= last_key_d;
`endif
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ev.ev_valid = !empty;
    assign ev.ev_ext   = mem_q[rd_q[AW-1:0]][9];
    assign ev.ev_break = mem_q[rd_q[AW-1:0]][8];
    assign ev.ev_code  = mem_q[rd_q[AW-1:0]][7:0];
    assign key_held    = key_held_q;
    assign frame_err   = frame_err_q;
    assign overflow    = ovf_q;
endmodule
